mem_responder: RTL and testbench
================================

# mem_responder

Single-outstanding memory responder for the core's load/store and fetch traffic. It accepts word-addressed read/write requests over a valid/ready request channel and returns one response per request after a programmable access latency. Storage is a byte-maskable word array. It sits at the memory end of the CPU's memory interface and replaces the ideal zero-latency memory used in early bring-up.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words stored.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `LATENCY`, default 2, legal 1..15: cycles from request handshake to `rsp_valid`.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  1: a request is present.
- `req_ready`  out  1: the responder can accept a request.
- `req_addr`  in  32: byte address.
- `req_wen`  in  1: 1 = write, 0 = read.
- `req_wdata`  in  32: write data.
- `req_wmask`  in  4: byte-lane enables; bit i enables `wdata[8i+7:8i]`.
- `rsp_valid`  out  1: a response is present.
- `rsp_ready`  in  1: the requester accepts the response.
- `rsp_rdata`  out  32: read data, or 0 for writes and errors.
- `rsp_err`  out  1: the access was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid&&req_ready`, latch addr, wen, wdata and wmask.
  - If LATENCY==1, go to RESP.
  - Otherwise go to WAIT with counter = LATENCY-2.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP.
- Access is done on the transition into RESP:
  - Offset = addr - BASE_ADDR (32-bit unsigned).
  - Error if addr[1:0]!=0 or offset >= DEPTH_WORDS*4. On error: no write, `rsp_rdata`=0, `rsp_err`=1.
  - Read: `rsp_rdata` = mem[offset>>2], `rsp_err`=0.
  - Write: update only the enabled byte lanes. `rsp_rdata`=0, `rsp_err`=0. A wmask of 0 is a legal no-op write.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` are registered and held stable until `rsp_valid&&rsp_ready`, then go to IDLE.
- Request-side inputs are ignored outside the IDLE handshake. Only one request is outstanding at a time.
- Memory contents are not reset (undefined until written).

## Timing
- Reset: while `rst`=1 at a rising edge, the state becomes IDLE and the counter clears.
  - `req_ready` is forced to 0 combinationally while `rst`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready`=1 in the first cycle with `rst`=0.
- Latency: with the request handshake in cycle T, `rsp_valid` is high from cycle T+LATENCY.
- Throughput: if the response handshake occurs in cycle R, `req_ready`=1 in cycle R+1. Minimum request spacing is LATENCY+1 cycles. `req_ready` and `rsp_valid` are never high in the same cycle.
- Write visibility: a read accepted after a write's response handshake returns the written data.
- Reset mid-operation:
  - Reset in WAIT aborts the request. A pending write is not performed and no response is produced.
  - Reset in RESP drops the response. A write already performed stays performed.
- `rsp_valid` never deasserts without a handshake, except on reset.

## Test plan
- Full write then read (LATENCY=2): write 0xDEADBEEF with mask 4'hF to 0x8000_0000, then read the same address.
  - Write response: `rdata`=0, `err`=0 at T+2.
  - Read response: `rdata`=0xDEADBEEF, `err`=0 at T+2.
- Byte mask: write 0x11223344 to 0x8000_0010, then write 0x0000AA00 with mask 4'b0010. A read returns 0x1122AA44.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - `rsp_valid`, `rsp_rdata` and `rsp_err` stay constant and `req_ready` stays 0.
  - Handshake on the 6th cycle; `req_ready`=1 in the next cycle.
- Errors (DEPTH_WORDS=1024):
  - Read of 0x8000_0002 → `err`=1, `rdata`=0.
  - Write of 0xFFFFFFFF to 0x8000_1000 → `err`=1.
  - Write of 0xFFFFFFFF to 0x7FFF_FFFC → `err`=1.
  - Afterwards, a read of 0x8000_0000 still returns its prior value.
- Reset abort (LATENCY=4): accept a write of 0x55AA55AA to 0x8000_0020 holding 0x12345678, assert `rst` for 1 cycle during WAIT.
  - No `rsp_valid`, and `req_ready`=1 in the first cycle after reset.
  - A subsequent read returns 0x12345678.
- Streaming (LATENCY=1 and LATENCY=3, `req_valid` and `rsp_ready` held high, 8 reads): requests are accepted every 2 and every 4 cycles respectively, with responses in order and correct data.

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one word-addressed read/write
// request, performs the byte-masked access after LATENCY cycles, and holds the response.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic            req_hs;
    logic            do_access;
    logic [31:0]     acc_addr;
    logic            acc_wen;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_wmask;
    logic [31:0]     acc_off;
    logic            acc_err;
    logic [IDXW-1:0] acc_idx;
    logic            mem_we;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP) && !rst;
    assign rsp_rdata = rst ? '0 : rdata_q;
    assign rsp_err   = rst ? 1'b0 : err_q;
    assign req_hs    = req_valid && req_ready;

    // With LATENCY==1 the access happens on the handshake edge itself, so the
    // live request fields are used instead of the not-yet-latched copies.
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wen   = (state_q == IDLE) ? req_wen   : wen_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_wmask = (state_q == IDLE) ? req_wmask : wmask_q;
    assign acc_off   = acc_addr - BASE_ADDR;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_off} >= LIMIT);
    assign acc_idx   = acc_off[IDXW+1:2];
    assign mem_we    = do_access && !rst && acc_wen && !acc_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_hs) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_wen) ? '0 : mem[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances at LATENCY 2/4/1/3 share one clock,
// each with its own driver stimulus, reference memory and response monitor.
module tb_mem_responder;

    localparam int NI = 4;
    localparam int unsigned LATS [NI] = '{2, 4, 1, 3};
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   req_addr [NI];
    logic [31:0]   req_wdata [NI];
    logic [31:0]   rsp_rdata [NI];
    logic [3:0]    req_wmask [NI];

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      t;
    } exp_t;

    exp_t        sbq [NI][$];
    logic [31:0] mm  [NI][1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: flat word array indexed by (addr-BASE)/4, errors by plain arithmetic.
    function automatic exp_t model(input int g, input logic [31:0] a, input logic w,
                                   input logic [31:0] d, input logic [3:0] m, input longint t);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] wd;
        off     = a - BASE;
        e.t     = t;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if ((a % 4) != 0 || off >= 32'd4096) begin
            e.err = 1'b1;
        end else if (w) begin
            wd = mm[g][off / 4];
            for (int b = 0; b < 4; b++)
                if (m[b]) wd[8*b +: 8] = d[8*b +: 8];
            mm[g][off / 4] = wd;
        end else begin
            e.rdata = mm[g][off / 4];
        end
        return e;
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mem_responder #(
                .DEPTH_WORDS(1024),
                .BASE_ADDR  (32'h8000_0000),
                .LATENCY    (LATS[g])
            ) u_dut (
                .clk      (clk),
                .rst      (rst[g]),
                .req_valid(req_valid[g]),
                .req_ready(req_ready[g]),
                .req_addr (req_addr[g]),
                .req_wen  (req_wen[g]),
                .req_wdata(req_wdata[g]),
                .req_wmask(req_wmask[g]),
                .rsp_valid(rsp_valid[g]),
                .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]),
                .rsp_err  (rsp_err[g])
            );

            bit          held_v = 1'b0;
            logic [31:0] held_d;
            logic        held_e;
            exp_t        e;

            always begin
                @(negedge clk);
                #2;
                if (rst[g]) begin
                    held_v = 1'b0;
                end else if (rsp_valid[g]) begin
                    chk($sformatf("i%0d_ready_in_resp", g), 64'(req_ready[g]), 64'd0);
                    if (held_v) begin
                        chk($sformatf("i%0d_hold_rdata", g), 64'(rsp_rdata[g]), 64'(held_d));
                        chk($sformatf("i%0d_hold_err", g), 64'(rsp_err[g]), 64'(held_e));
                    end else if (sbq[g].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL i%0d_unexpected_rsp: rsp_valid=1 required 0", g);
                    end else begin
                        chk($sformatf("i%0d_latency", g), 64'(cyc - sbq[g][0].t), 64'(LATS[g]));
                    end
                    if (rsp_ready[g]) begin
                        if (sbq[g].size() > 0) begin
                            e = sbq[g].pop_front();
                            chk($sformatf("i%0d_rdata", g), 64'(rsp_rdata[g]), 64'(e.rdata));
                            chk($sformatf("i%0d_err", g), 64'(rsp_err[g]), 64'(e.err));
                        end
                        held_v = 1'b0;
                    end else begin
                        held_v = 1'b1;
                        held_d = rsp_rdata[g];
                        held_e = rsp_err[g];
                    end
                end else if (held_v) begin
                    tests++;
                    fails++;
                    $display("FAIL i%0d_valid_dropped: rsp_valid=0 required 1", g);
                    held_v = 1'b0;
                end
            end
        end
    endgenerate

    // Called at a falling edge; leaves req_valid high so back-to-back calls stream.
    task automatic issue(input int g, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m, input bit score, output longint t);
        int n = 0;
        req_valid[g] = 1'b1;
        req_addr[g]  = a;
        req_wen[g]   = w;
        req_wdata[g] = d;
        req_wmask[g] = m;
        while (!req_ready[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[g]) begin
            tests++;
            fails++;
            $display("FAIL i%0d_req_timeout: req_ready=0 required 1", g);
            req_valid[g] = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        if (score) sbq[g].push_back(model(g, a, w, d, m, t));
        @(negedge clk);
    endtask

    task automatic drain(input int g, input bit rand_bp);
        int n = 0;
        while (sbq[g].size() != 0 && n < 300) begin
            rsp_ready[g] = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
        end
        rsp_ready[g] = 1'b1;
        if (sbq[g].size() != 0) begin
            tests++;
            fails++;
            $display("FAIL i%0d_rsp_timeout: %0d pending required 0", g, sbq[g].size());
            sbq[g].delete();
        end
    endtask

    task automatic op(input int g, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] m, input bit rand_bp = 1'b0);
        longint t;
        issue(g, a, w, d, m, 1'b1, t);
        req_valid[g] = 1'b0;
        drain(g, rand_bp);
        @(negedge clk);
    endtask

    task automatic stream(input int g);
        longint t, prev;
        for (int i = 0; i < 8; i++)
            op(g, BASE + 32'h40 + 32'(4 * i), 1'b1, $urandom, 4'hF);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            issue(g, BASE + 32'h40 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 1'b1, t);
            if (i > 0) chk($sformatf("i%0d_stream_spacing", g), 64'(t - prev), 64'(LATS[g] + 1));
            prev = t;
        end
        req_valid[g] = 1'b0;
        drain(g, 1'b0);
    endtask

    task automatic random_ops(input int g);
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 16; i++)
            op(g, BASE + 32'h100 + 32'(4 * i), 1'b1, $urandom, 4'hF);
        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 7));
            else if (r == 2) a = BASE - 32'(4 * $urandom_range(1, 8));
            op(g, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint t;
        int     n;
        rst       = '1;
        req_valid = '0;
        req_wen   = '0;
        rsp_ready = '1;
        for (int g = 0; g < NI; g++) begin
            req_addr[g]  = '0;
            req_wdata[g] = '0;
            req_wmask[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_rst_req_ready", g), 64'(req_ready[g]), 64'd0);
            chk($sformatf("i%0d_rst_rsp_valid", g), 64'(rsp_valid[g]), 64'd0);
            chk($sformatf("i%0d_rst_rdata", g), 64'(rsp_rdata[g]), 64'd0);
            chk($sformatf("i%0d_rst_err", g), 64'(rsp_err[g]), 64'd0);
        end
        rst = '0;
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk($sformatf("i%0d_post_rst_ready", g), 64'(req_ready[g]), 64'd1);

        // LATENCY=2: write/read, byte mask, error cases
        op(0, BASE, 1'b1, 32'hDEAD_BEEF, 4'hF);
        op(0, BASE, 1'b0, 32'h0, 4'h0);
        op(0, BASE + 32'h10, 1'b1, 32'h1122_3344, 4'hF);
        op(0, BASE + 32'h10, 1'b1, 32'h0000_AA00, 4'b0010);
        op(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0);
        op(0, BASE + 32'h2, 1'b0, 32'h0, 4'h0);
        op(0, BASE + 32'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF);
        op(0, 32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF);
        op(0, BASE, 1'b1, 32'h0BAD_F00D, 4'h0);
        op(0, BASE, 1'b0, 32'h0, 4'h0);

        // Backpressure: five stalled response cycles, handshake on the sixth
        rsp_ready[0] = 1'b0;
        issue(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b1, t);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid_seen", 64'(rsp_valid[0]), 64'd1);
        repeat (5) begin
            chk("bp_req_ready_low", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_after", 64'(req_ready[0]), 64'd1);
        drain(0, 1'b0);

        // LATENCY=4: reset during WAIT aborts a pending write
        op(1, BASE + 32'h20, 1'b1, 32'h1234_5678, 4'hF);
        issue(1, BASE + 32'h20, 1'b1, 32'h55AA_55AA, 4'hF, 1'b0, t);
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        #1;
        chk("abort_ready_in_rst", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("abort_ready_after_rst", 64'(req_ready[1]), 64'd1);
        repeat (8) @(negedge clk);
        op(1, BASE + 32'h20, 1'b0, 32'h0, 4'h0);

        // Streaming at LATENCY=1 and LATENCY=3
        stream(2);
        stream(3);

        for (int g = 0; g < NI; g++) random_ops(g);

        repeat (5) @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk($sformatf("i%0d_queue_empty", g), 64'(sbq[g].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
